// File: rtl/if_predec.sv
// Fetch-word predecoder: splits 32-bit fetch words into 16/32-bit instructions,
// carrying a leftover halfword across words, and flags jal/jalr/branch with offsets.
module if_predec #(
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned RVC_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [31:0]        i_data,
  input  logic [PC_SIZE-1:0] i_pc,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [31:0]        o_ir,
  output logic [PC_SIZE-1:0] o_pc,
  output logic               o_if32,
  output logic               o_jal,
  output logic               o_jalr,
  output logic               o_bxx,
  output logic               o_ifj,
  output logic [31:0]        o_bjp_imm,
  output logic [4:0]         o_jalr_rs1_idx
);

  typedef enum logic [0:0] {EMPTY = 1'b0, HALF = 1'b1} state_t;

  typedef struct packed {
    logic        if32;
    logic        jal;
    logic        jalr;
    logic        bxx;
    logic [31:0] imm;
    logic [4:0]  rs1;
  } dec_t;

  // Branch/jump predecode of one instruction; all fields zero when nothing matches.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d = '0;
    if ((ir[1:0] == 2'b11) || (RVC_EN == 0)) begin
      d.if32 = 1'b1;
      case (ir[6:0])
        7'b1101111: begin
          d.jal = 1'b1;
          d.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        end
        7'b1100111: begin
          d.jalr = 1'b1;
          d.imm  = {{20{ir[31]}}, ir[31:20]};
          d.rs1  = ir[19:15];
        end
        7'b1100011: begin
          d.bxx = 1'b1;
          d.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        end
        default: d = d;
      endcase
    end else begin
      case ({ir[1:0], ir[15:13]})
        5'b01_101, 5'b01_001: begin
          d.jal = 1'b1;
          d.imm = {{21{ir[12]}}, ir[8], ir[10:9], ir[6], ir[7], ir[2], ir[11], ir[5:3], 1'b0};
        end
        5'b01_110, 5'b01_111: begin
          d.bxx = 1'b1;
          d.imm = {{24{ir[12]}}, ir[6:5], ir[2], ir[11:10], ir[4:3], 1'b0};
        end
        5'b10_100: begin
          if ((ir[6:2] == 5'd0) && (ir[11:7] != 5'd0)) begin
            d.jalr = 1'b1;
            d.rs1  = ir[11:7];
          end else begin
            d.jalr = 1'b0;
          end
        end
        default: d = d;
      endcase
    end
    return d;
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          lo_q, lo_d;
  logic [PC_SIZE-1:0]   lo_pc_q, lo_pc_d;
  logic                 load_en;
  logic                 lo_is32;
  logic                 accept;
  logic                 emit;
  logic [31:0]          emit_ir;
  logic [PC_SIZE-1:0]   emit_pc;
  dec_t                 dec;

  logic                 o_valid_q;
  logic [31:0]          o_ir_q;
  logic [PC_SIZE-1:0]   o_pc_q;
  dec_t                 dec_q;
  logic                 ifj_q;

  assign load_en = ~o_valid_q | o_ready;
  assign lo_is32 = (lo_q[1:0] == 2'b11);
  assign i_ready = load_en & ~i_flush & ~((state_q == HALF) & ~lo_is32);
  assign accept  = i_valid & i_ready;

  // Next-state, leftover update and instruction selection.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    lo_pc_d = lo_pc_q;
    emit    = 1'b0;
    emit_ir = 32'd0;
    emit_pc = '0;
    if (i_flush) begin
      state_d = EMPTY;
      lo_d    = 16'd0;
      lo_pc_d = '0;
    end else if (load_en) begin
      case (state_q)
        EMPTY: begin
          if (!accept) begin
            emit = 1'b0;
          end else if ((RVC_EN == 0) || (!i_pc[1] && (i_data[1:0] == 2'b11))) begin
            emit    = 1'b1;
            emit_ir = i_data;
            emit_pc = i_pc;
          end else if (!i_pc[1]) begin
            emit    = 1'b1;
            emit_ir = {16'd0, i_data[15:0]};
            emit_pc = i_pc;
            lo_d    = i_data[31:16];
            lo_pc_d = i_pc + PC_SIZE'(2);
            state_d = HALF;
          end else begin
            // Odd start: lower halfword is not part of the stream.
            lo_d    = i_data[31:16];
            lo_pc_d = i_pc;
            state_d = HALF;
          end
        end
        HALF: begin
          if (!lo_is32) begin
            emit    = 1'b1;
            emit_ir = {16'd0, lo_q};
            emit_pc = lo_pc_q;
            state_d = EMPTY;
          end else if (accept) begin
            emit    = 1'b1;
            emit_ir = {i_data[15:0], lo_q};
            emit_pc = lo_pc_q;
            lo_d    = i_data[31:16];
            lo_pc_d = i_pc + PC_SIZE'(2);
          end else begin
            emit = 1'b0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      emit = 1'b0;
    end
  end

  assign dec = emit ? decode(emit_ir) : '0;

  // State and leftover halfword registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      lo_q    <= 16'd0;
      lo_pc_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      lo_pc_q <= lo_pc_d;
    end
  end

  // Output register: loads when downstream can take it, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_ir_q    <= 32'd0;
      o_pc_q    <= '0;
      dec_q     <= '0;
      ifj_q     <= 1'b0;
    end else if (i_flush) begin
      o_valid_q <= 1'b0;
    end else if (load_en) begin
      o_valid_q <= emit;
      o_ir_q    <= emit_ir;
      o_pc_q    <= emit_pc;
      dec_q     <= dec;
      ifj_q     <= dec.jal | dec.jalr | dec.bxx;
    end
  end

  assign o_valid        = o_valid_q;
  assign o_ir           = o_ir_q;
  assign o_pc           = o_pc_q;
  assign o_if32         = dec_q.if32;
  assign o_jal          = dec_q.jal;
  assign o_jalr         = dec_q.jalr;
  assign o_bxx          = dec_q.bxx;
  assign o_ifj          = ifj_q;
  assign o_bjp_imm      = dec_q.imm;
  assign o_jalr_rs1_idx = dec_q.rs1;

endmodule

// File: tb/tb_if_predec.sv
// Directed bench for if_predec: one task per scenario, hand-computed expectations.
module tb_if_predec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_flush, o_ready;
  logic [31:0] i_data, i_pc;
  logic        i_ready, o_valid, o_if32, o_jal, o_jalr, o_bxx, o_ifj;
  logic [31:0] o_ir, o_pc, o_bjp_imm;
  logic [4:0]  o_jalr_rs1_idx;
  logic        n_i_ready, n_o_valid, n_o_if32, n_o_jal, n_o_jalr, n_o_bxx, n_o_ifj;
  logic [31:0] n_o_ir, n_o_pc, n_o_bjp_imm;
  logic [4:0]  n_o_rs1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  if_predec #(.PC_SIZE(32), .RVC_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .o_ready(o_ready), .o_ir(o_ir),
    .o_pc(o_pc), .o_if32(o_if32), .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx),
    .o_ifj(o_ifj), .o_bjp_imm(o_bjp_imm), .o_jalr_rs1_idx(o_jalr_rs1_idx)
  );

  if_predec #(.PC_SIZE(32), .RVC_EN(0)) u_dut_norvc (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(n_i_ready), .i_data(i_data),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(n_o_valid), .o_ready(o_ready), .o_ir(n_o_ir),
    .o_pc(n_o_pc), .o_if32(n_o_if32), .o_jal(n_o_jal), .o_jalr(n_o_jalr), .o_bxx(n_o_bxx),
    .o_ifj(n_o_ifj), .o_bjp_imm(n_o_bjp_imm), .o_jalr_rs1_idx(n_o_rs1)
  );

  task automatic send(input logic [31:0] d, input logic [31:0] pc);
    i_valid = 1'b1;
    i_data  = d;
    i_pc    = pc;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; o_ready = 1'b1;
    i_data = 32'd0; i_pc = 32'd0;
    repeat (2) @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", o_valid); fails++; end
    checks++; if ({o_ir, o_pc, o_bjp_imm} !== 96'd0) begin $display("FAIL reset_data got=%h/%h/%h exp=0", o_ir, o_pc, o_bjp_imm); fails++; end
    checks++; if ({o_if32, o_jal, o_jalr, o_bxx, o_ifj, o_jalr_rs1_idx} !== 10'd0) begin $display("FAIL reset_flags got=%b exp=0", {o_if32, o_jal, o_jalr, o_bxx, o_ifj, o_jalr_rs1_idx}); fails++; end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin $display("FAIL reset_iready got=%b exp=1", i_ready); fails++; end
  endtask

  task automatic test_rvc_off();
    send(32'h8282A011, 32'h100);
    checks++; if (n_o_valid !== 1'b1 || n_o_ir !== 32'h8282A011 || n_o_pc !== 32'h100) begin $display("FAIL norvc_word got=%b/%h/%h exp=1/8282a011/100", n_o_valid, n_o_ir, n_o_pc); fails++; end
    checks++; if (n_o_if32 !== 1'b1 || n_o_ifj !== 1'b0) begin $display("FAIL norvc_flags got=%b%b exp=10", n_o_if32, n_o_ifj); fails++; end
    @(posedge clk); #1;
    checks++; if (n_o_valid !== 1'b0) begin $display("FAIL norvc_nohalf got=%b exp=0", n_o_valid); fails++; end
  endtask

  task automatic test_jal();
    send(32'h008000EF, 32'h100);
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h008000EF || o_pc !== 32'h100) begin $display("FAIL jal_word got=%b/%h/%h exp=1/008000ef/100", o_valid, o_ir, o_pc); fails++; end
    checks++; if ({o_if32, o_jal, o_jalr, o_bxx, o_ifj} !== 5'b11001) begin $display("FAIL jal_flags got=%b exp=11001", {o_if32, o_jal, o_jalr, o_bxx, o_ifj}); fails++; end
    checks++; if (o_bjp_imm !== 32'h8) begin $display("FAIL jal_imm got=%h exp=8", o_bjp_imm); fails++; end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin $display("FAIL idle_valid got=%b exp=0", o_valid); fails++; end
  endtask

  task automatic test_cj_cjr();
    send(32'h8282A011, 32'h100);
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h0000A011 || o_pc !== 32'h100) begin $display("FAIL cj_word got=%b/%h/%h exp=1/0000a011/100", o_valid, o_ir, o_pc); fails++; end
    checks++; if ({o_if32, o_jal, o_ifj} !== 3'b011 || o_bjp_imm !== 32'h4) begin $display("FAIL cj_dec got=%b/%h exp=011/4", {o_if32, o_jal, o_ifj}, o_bjp_imm); fails++; end
    checks++; if (i_ready !== 1'b0) begin $display("FAIL cj_iready got=%b exp=0", i_ready); fails++; end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h00008282 || o_pc !== 32'h102) begin $display("FAIL cjr_word got=%b/%h/%h exp=1/00008282/102", o_valid, o_ir, o_pc); fails++; end
    checks++; if ({o_jal, o_jalr, o_ifj} !== 3'b011 || o_jalr_rs1_idx !== 5'd5 || o_bjp_imm !== 32'd0) begin $display("FAIL cjr_dec got=%b/%0d/%h exp=011/5/0", {o_jal, o_jalr, o_ifj}, o_jalr_rs1_idx, o_bjp_imm); fails++; end
    checks++; if (i_ready !== 1'b1) begin $display("FAIL cjr_iready got=%b exp=1", i_ready); fails++; end
    @(posedge clk); #1;
  endtask

  task automatic test_straddle();
    send(32'h00EF0001, 32'h200);
    checks++; if (o_ir !== 32'h00000001 || o_pc !== 32'h200 || o_if32 !== 1'b0 || o_ifj !== 1'b0) begin $display("FAIL strad_nop0 got=%h/%h/%b exp=00000001/200/0", o_ir, o_pc, o_if32); fails++; end
    checks++; if (i_ready !== 1'b1) begin $display("FAIL strad_iready got=%b exp=1", i_ready); fails++; end
    send(32'h00010080, 32'h204);
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h008000EF || o_pc !== 32'h202) begin $display("FAIL strad_jal got=%b/%h/%h exp=1/008000ef/202", o_valid, o_ir, o_pc); fails++; end
    checks++; if (o_jal !== 1'b1 || o_if32 !== 1'b1 || o_bjp_imm !== 32'h8) begin $display("FAIL strad_jaldec got=%b%b/%h exp=11/8", o_jal, o_if32, o_bjp_imm); fails++; end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h00000001 || o_pc !== 32'h206) begin $display("FAIL strad_nop1 got=%b/%h/%h exp=1/00000001/206", o_valid, o_ir, o_pc); fails++; end
    @(posedge clk); #1;
  endtask

  task automatic test_odd_start();
    send(32'hDC75ABCD, 32'h402);
    checks++; if (o_valid !== 1'b0) begin $display("FAIL odd_noemit got=%b exp=0", o_valid); fails++; end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h0000DC75 || o_pc !== 32'h402) begin $display("FAIL odd_word got=%b/%h/%h exp=1/0000dc75/402", o_valid, o_ir, o_pc); fails++; end
    checks++; if ({o_bxx, o_ifj, o_if32} !== 3'b110 || o_bjp_imm !== 32'hFFFFFFFC) begin $display("FAIL odd_cb got=%b/%h exp=110/fffffffc", {o_bxx, o_ifj, o_if32}, o_bjp_imm); fails++; end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    o_ready = 1'b0;
    i_valid = 1'b1; i_data = 32'hFE000CE3; i_pc = 32'h300;
    @(posedge clk); #1;
    i_data = 32'h00000013; i_pc = 32'h304;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_valid !== 1'b1 || o_ir !== 32'hFE000CE3 || o_pc !== 32'h300) begin $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/fe000ce3/300", k, o_valid, o_ir, o_pc); fails++; end
      checks++; if (o_bxx !== 1'b1 || o_bjp_imm !== 32'hFFFFFFF8 || i_ready !== 1'b0) begin $display("FAIL bp_dec%0d got=%b/%h/%b exp=1/fffffff8/0", k, o_bxx, o_bjp_imm, i_ready); fails++; end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin $display("FAIL bp_release got=%b exp=1", i_ready); fails++; end
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if (o_ir !== 32'h00000013 || o_pc !== 32'h304 || o_bxx !== 1'b0) begin $display("FAIL bp_next got=%h/%h/%b exp=00000013/304/0", o_ir, o_pc, o_bxx); fails++; end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    send(32'h00EF0001, 32'h400);
    i_flush = 1'b1; i_valid = 1'b1; i_data = 32'h12345678; i_pc = 32'h404;
    #1;
    checks++; if (i_ready !== 1'b0) begin $display("FAIL flush_iready got=%b exp=0", i_ready); fails++; end
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin $display("FAIL flush_valid got=%b exp=0", o_valid); fails++; end
    send(32'h00000013, 32'h300);
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h00000013 || o_pc !== 32'h300 || o_if32 !== 1'b1) begin $display("FAIL flush_after got=%b/%h/%h exp=1/00000013/300", o_valid, o_ir, o_pc); fails++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send(32'h00EF0001, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_ir !== 32'd0 || o_pc !== 32'd0) begin $display("FAIL rstmid_out got=%b/%h/%h exp=0/0/0", o_valid, o_ir, o_pc); fails++; end
    @(negedge clk); rst_n = 1'b1;
    send(32'h00000013, 32'h600);
    checks++; if (o_valid !== 1'b1 || o_ir !== 32'h00000013 || o_pc !== 32'h600) begin $display("FAIL rstmid_after got=%b/%h/%h exp=1/00000013/600", o_valid, o_ir, o_pc); fails++; end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rvc_off();
    @(posedge clk); #1;
    test_jal();
    test_cj_cjr();
    test_straddle();
    test_odd_start();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_predec.md
IF_PREDEC -- requirements
Module: if_predec

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32: width of all PC ports.
REQ-002 SHALL have parameter RVC_EN, default 1: 1 enables 16-bit (C) instruction extraction; 0 treats every fetch word as one 32-bit instruction.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, 1: fetch word valid.
REQ-006 SHALL have port i_ready, output, 1: fetch word accepted when i_valid & i_ready.
REQ-007 SHALL have port i_data, input, 32: fetch word; bits [15:0] are the lower halfword at the word-aligned address.
REQ-008 SHALL have port i_pc, input, PC_SIZE: halfword-aligned PC of the first useful halfword; bit 1 selects the starting halfword.
REQ-009 SHALL have port i_flush, input, 1: redirect; discards all buffered state.
REQ-010 SHALL have ports o_valid (output, 1) and o_ready (input, 1): decoded-instruction handshake.
REQ-011 SHALL have port o_ir, output, 32: instruction, upper 16 bits zero for 16-bit.
REQ-012 SHALL have port o_pc, output, PC_SIZE: instruction PC.
REQ-013 SHALL have 1-bit outputs o_if32, o_jal, o_jalr, o_bxx, o_ifj (= o_jal|o_jalr|o_bxx).
REQ-014 SHALL have port o_bjp_imm, output, 32: sign-extended branch/jump offset.
REQ-015 SHALL have port o_jalr_rs1_idx, output, 5: jalr base register index.

Function
REQ-016 SHALL hold a one-halfword leftover buffer (data + PC) and a 2-state FSM: EMPTY, HALF (leftover valid).
REQ-017 SHALL register all o_* outputs; output register loads when load_en = ~o_valid | o_ready; holds stable otherwise.
REQ-018 SHALL drive i_ready = load_en & ~i_flush & ~(HALF & leftover is 16-bit).
REQ-019 SHALL, EMPTY, accepted word, i_pc[1]=0, i_data[1:0]=11: emit i_data at i_pc, stay EMPTY.
REQ-020 SHALL, EMPTY, accepted word, i_pc[1]=0, i_data[1:0]!=11: emit i_data[15:0] at i_pc; leftover = i_data[31:16], PC i_pc+2; go HALF.
REQ-021 SHALL, EMPTY, accepted word, i_pc[1]=1: leftover = i_data[31:16], PC i_pc; go HALF; no emission.
REQ-022 SHALL, HALF, leftover[1:0]!=11: emit leftover at leftover PC without consuming input; go EMPTY.
REQ-023 SHALL, HALF, leftover[1:0]=11, accepted word: emit {i_data[15:0], leftover} at leftover PC; leftover = i_data[31:16], PC i_pc+2; stay HALF.
REQ-024 SHALL, when RVC_EN=0, apply only REQ-019 behaviour and never enter HALF.
REQ-025 SHALL set o_valid=0 when load_en and nothing is emitted.
REQ-026 SHALL decode RV32: jal 1101111, jalr 1100111 (rs1 = ir[19:15], I-imm), branch 1100011 (B-imm).
REQ-027 SHALL decode RVC: c.j (q01,f3=101) and c.jal (q01,f3=001) as o_jal with CJ-imm; c.jr/c.jalr (q10,f3=100, rs2=0, rs1!=0) as o_jalr, rs1 = ir[11:7], imm 0; c.beqz/c.bnez (q01,f3=110/111) as o_bxx with CB-imm.
REQ-028 SHALL drive o_bjp_imm=0 and o_jalr_rs1_idx=0 when not applicable.
REQ-029 SHALL, on i_flush, force state EMPTY and o_valid=0 next cycle regardless of o_ready; input that cycle is ignored.
REQ-030 SHALL treat a non-contiguous i_pc in HALF without preceding flush as illegal (no defined result).

Reset
REQ-031 SHALL, on rst_n low (any cycle, including mid-HALF), asynchronously set state EMPTY, leftover and its PC 0, o_valid 0, all other o_* 0.

Verification
REQ-032 SHALL cover: i_data=0x008000EF, i_pc=0x100 -> o_ir=0x008000EF, o_pc=0x100, o_if32=1, o_jal=1, o_bjp_imm=0x8.
REQ-033 SHALL cover: i_data=0x8282A011, i_pc=0x100 -> c.j at 0x100 imm 0x4; next cycle i_ready=0, c.jr at 0x102, o_jalr=1, rs1_idx=5, imm 0.
REQ-034 SHALL cover straddle: 0x00EF0001 @0x200 then 0x00010080 @0x204 -> c.nop @0x200, jal 0x008000EF @0x202 imm 0x8, c.nop @0x206.
REQ-035 SHALL cover: i_data=0xFE000CE3 with o_ready=0 for 3 cycles -> o_bxx=1, o_bjp_imm=0xFFFFFFF8 held stable, i_ready=0 until o_ready=1.
REQ-036 SHALL cover: i_flush while HALF with leftover 0x00EF -> next cycle o_valid=0, EMPTY; following 0x00000013 @0x300 emits at 0x300.
REQ-037 SHALL cover: rst_n low mid-HALF -> o_valid=0 immediately, state EMPTY after release.
